pcie_rx_req_decode: RTL and testbench

PCIE_RX_REQ_DECODE -- requirements
Module: pcie_rx_req_decode

---
 rtl/pcie_rx_req_decode.sv | 198 +++++++++++++++++++
 tb/tb_pcie_rx_req_decode.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rx_req_decode.sv
// PCIe RX request decoder: classifies single-DW memory requests from a 256-bit
// Avalon-ST stream into a small descriptor FIFO; unsupported non-posted requests become UR descriptors.
module pcie_rx_req_decode #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  BAR_MASK   = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] rx_st_data,
  input  logic         rx_st_sop,
  input  logic         rx_st_eop,
  input  logic         rx_st_valid,
  input  logic         rx_st_err,
  input  logic [7:0]   rx_st_bar,
  output logic         rx_st_ready,
  output logic         desc_valid,
  input  logic         desc_ready,
  output logic         desc_ur,
  output logic         desc_is_wr,
  output logic [61:0]  desc_addr,
  output logic [31:0]  desc_wdata,
  output logic [3:0]   desc_fbe,
  output logic [15:0]  desc_req_id,
  output logic [7:0]   desc_tag,
  output logic [2:0]   desc_tc,
  output logic [1:0]   desc_attr,
  output logic [2:0]   desc_bar,
  output logic [15:0]  drop_cnt
);

  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic        ur;
    logic        is_wr;
    logic [61:0] addr;
    logic [31:0] wdata;
    logic [3:0]  fbe;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [2:0]  bar;
  } desc_t;

  typedef enum logic {IDLE, DISCARD} state_t;

  state_t state, state_nxt;

  logic [31:0] dw0, dw1, dw2, dw3, dw4;
  logic [1:0]  fmt;
  logic [4:0]  pkt_type;
  logic [9:0]  len;
  logic        ep;
  logic        bar_hit;
  logic [2:0]  bar_enc;
  logic [61:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        unused_bits;

  assign dw0 = rx_st_data[31:0];
  assign dw1 = rx_st_data[63:32];
  assign dw2 = rx_st_data[95:64];
  assign dw3 = rx_st_data[127:96];
  assign dw4 = rx_st_data[159:128];

  assign fmt      = dw0[30:29];
  assign pkt_type = dw0[28:24];
  assign len      = dw0[9:0];
  assign ep       = dw0[14];
  assign bar_hit  = |(rx_st_bar & BAR_MASK);

  // fmt[0] selects the 4DW header; a 3DW write with a QW-aligned address carries its data in DW4
  assign mem_addr  = fmt[0] ? {dw2, dw3[31:2]} : {32'h0, dw2[31:2]};
  assign mem_wdata = (!fmt[0] && dw2[2]) ? dw3 : dw4;

  assign unused_bits = ^{rx_st_data[255:160], dw0[31], dw0[23], dw0[19:15], dw0[11:10], dw1[7:4]};

  logic          accept, push, pop, drop;
  logic          fifo_full, fifo_empty;
  desc_t         new_desc, head;
  desc_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  assign fifo_full   = (count == DEPTH);
  assign fifo_empty  = (count == '0);
  assign rx_st_ready = !fifo_full;
  assign accept      = rx_st_valid && rx_st_ready;
  assign desc_valid  = !fifo_empty;
  assign pop         = desc_valid && desc_ready;

  always_comb begin
    bar_enc = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (rx_st_bar[7 - i]) bar_enc = 3'(7 - i);
    end
  end

  always_comb begin
    push     = 1'b0;
    drop     = 1'b0;
    new_desc = '0;
    if (accept && rx_st_sop) begin
      new_desc.req_id = dw1[31:16];
      new_desc.tag    = dw1[15:8];
      new_desc.tc     = dw0[22:20];
      new_desc.attr   = dw0[13:12];
      if (rx_st_err) begin
        drop = 1'b1;
      end else if (pkt_type == 5'b00000 && !fmt[1]) begin
        push = 1'b1;
        if (len == 10'd1 && bar_hit) begin
          new_desc.addr = mem_addr;
          new_desc.fbe  = dw1[3:0];
          new_desc.bar  = bar_enc;
        end else begin
          new_desc.ur = 1'b1;
        end
      end else if (pkt_type == 5'b00000) begin
        if (len == 10'd1 && !ep && bar_hit) begin
          push           = 1'b1;
          new_desc.is_wr = 1'b1;
          new_desc.addr  = mem_addr;
          new_desc.wdata = mem_wdata;
          new_desc.fbe   = dw1[3:0];
          new_desc.bar   = bar_enc;
        end else begin
          drop = 1'b1;
        end
      end else if ((pkt_type == 5'b00001 && !fmt[1]) || pkt_type == 5'b00010 ||
                   pkt_type == 5'b00100 || pkt_type == 5'b00101) begin
        push        = 1'b1;
        new_desc.ur = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Classification happens on any accepted sop; the state only tracks whether trailing beats belong to a TLP
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (rx_st_sop)                         state_nxt = rx_st_eop ? IDLE : DISCARD;
      else if (state == DISCARD && rx_st_eop) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_desc;
  end

  // Storage is not reset, so the head is masked to keep outputs at zero while empty
  assign head = fifo_empty ? '0 : mem[rd_ptr];

  assign desc_ur     = head.ur;
  assign desc_is_wr  = head.is_wr;
  assign desc_addr   = head.addr;
  assign desc_wdata  = head.wdata;
  assign desc_fbe    = head.fbe;
  assign desc_req_id = head.req_id;
  assign desc_tag    = head.tag;
  assign desc_tc     = head.tc;
  assign desc_attr   = head.attr;
  assign desc_bar    = head.bar;

endmodule

// File: tb/tb_pcie_rx_req_decode.sv
// Self-checking bench for pcie_rx_req_decode: directed scenarios followed by random
// TLP traffic, all checked against a queue-based reference model.
module tb_pcie_rx_req_decode;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  MASK  = 8'h01;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] rx_st_data;
  logic         rx_st_sop, rx_st_eop, rx_st_valid, rx_st_err;
  logic [7:0]   rx_st_bar;
  logic         rx_st_ready;
  logic         desc_valid, desc_ready;
  logic         desc_ur, desc_is_wr;
  logic [61:0]  desc_addr;
  logic [31:0]  desc_wdata;
  logic [3:0]   desc_fbe;
  logic [15:0]  desc_req_id;
  logic [7:0]   desc_tag;
  logic [2:0]   desc_tc;
  logic [1:0]   desc_attr;
  logic [2:0]   desc_bar;
  logic [15:0]  drop_cnt;

  pcie_rx_req_decode #(.FIFO_DEPTH(DEPTH), .BAR_MASK(MASK)) dut (
    .clk(clk), .rst(rst),
    .rx_st_data(rx_st_data), .rx_st_sop(rx_st_sop), .rx_st_eop(rx_st_eop),
    .rx_st_valid(rx_st_valid), .rx_st_err(rx_st_err), .rx_st_bar(rx_st_bar),
    .rx_st_ready(rx_st_ready),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_ur(desc_ur), .desc_is_wr(desc_is_wr), .desc_addr(desc_addr),
    .desc_wdata(desc_wdata), .desc_fbe(desc_fbe), .desc_req_id(desc_req_id),
    .desc_tag(desc_tag), .desc_tc(desc_tc), .desc_attr(desc_attr),
    .desc_bar(desc_bar), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ur;
    logic        is_wr;
    logic [61:0] addr;
    logic [31:0] wdata;
    logic [3:0]  fbe;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [2:0]  bar;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   drops = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [1:0] fmt, input logic [4:0] typ,
                                      input logic [9:0] len, input logic ep,
                                      input logic [2:0] tc, input logic [1:0] attr,
                                      input logic [15:0] rid, input logic [7:0] tag,
                                      input logic [3:0] fbe, input logic [31:0] dw2,
                                      input logic [31:0] dw3, input logic [31:0] dw4);
    logic [255:0] d;
    d = {$urandom, $urandom, $urandom, 160'h0};
    d[31:0]    = {1'b0, fmt, typ, 1'b0, tc, 4'h0, 1'b0, ep, attr, 2'b00, len};
    d[63:32]   = {rid, tag, 4'h0, fbe};
    d[95:64]   = dw2;
    d[127:96]  = dw3;
    d[159:128] = dw4;
    return d;
  endfunction

  // Reference classification of one sop beat: returns 1 when a descriptor is expected
  function automatic bit classify(input logic [255:0] d, input logic er, input logic [7:0] b,
                                  output exp_t e);
    logic [31:0] w0, w1, w2, w3, w4;
    logic [1:0]  fmt;
    logic [4:0]  typ;
    bit          hit;
    w0 = d[31:0]; w1 = d[63:32]; w2 = d[95:64]; w3 = d[127:96]; w4 = d[159:128];
    fmt = w0[30:29];
    typ = w0[28:24];
    hit = (b & MASK) != 8'h00;
    e = '{ur: 1'b0, is_wr: 1'b0, addr: '0, wdata: '0, fbe: '0, req_id: w1[31:16],
          tag: w1[15:8], tc: w0[22:20], attr: w0[13:12], bar: '0};
    if (er) return 1'b0;
    if (typ == 5'd0) begin
      e.addr = fmt[0] ? {w2, w3[31:2]} : {32'h0, w2[31:2]};
      e.fbe  = w1[3:0];
      for (int k = 0; k < 8; k++) if (b[k]) begin e.bar = 3'(k); break; end
      if (!fmt[1]) begin
        if (w0[9:0] != 10'd1 || !hit) begin
          e.ur = 1'b1; e.addr = '0; e.fbe = '0; e.bar = '0;
        end
        return 1'b1;
      end
      if (w0[9:0] == 10'd1 && !w0[14] && hit) begin
        e.is_wr = 1'b1;
        e.wdata = (fmt[0] || !w2[2]) ? w4 : w3;
        return 1'b1;
      end
      return 1'b0;
    end
    if ((typ == 5'd1 && !fmt[1]) || typ == 5'd2 || typ == 5'd4 || typ == 5'd5) begin
      e.ur = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic cmp_head(input exp_t x);
    chk("desc_ur", desc_ur, x.ur);
    chk("desc_is_wr", desc_is_wr, x.is_wr);
    chk("desc_addr", desc_addr, x.addr);
    chk("desc_req_id", desc_req_id, x.req_id);
    chk("desc_tag", desc_tag, x.tag);
    chk("desc_tc", desc_tc, x.tc);
    chk("desc_attr", desc_attr, x.attr);
    if (x.is_wr || x.ur) chk("desc_wdata", desc_wdata, x.wdata);
    if (!x.ur) begin
      chk("desc_fbe", desc_fbe, x.fbe);
      chk("desc_bar", desc_bar, x.bar);
    end
  endtask

  // One clock cycle: called at a negedge, drives inputs, checks, steps the model, returns at next negedge
  task automatic tick(input logic [255:0] d, input logic s, input logic e, input logic v,
                      input logic er, input logic [7:0] b, input logic dr, input logic r,
                      output bit acc);
    bit   rdy_exp, pop;
    exp_t ne;
    rx_st_data = d; rx_st_sop = s; rx_st_eop = e; rx_st_valid = v;
    rx_st_err = er; rx_st_bar = b; desc_ready = dr; rst = r;
    #1;
    rdy_exp = q.size() < DEPTH;
    chk("rx_st_ready", rx_st_ready, rdy_exp);
    chk("desc_valid", desc_valid, q.size() != 0);
    chk("drop_cnt", drop_cnt, drops);
    if (q.size() != 0) cmp_head(q[0]);
    pop = (q.size() != 0) && dr;
    acc = v && rdy_exp;
    @(posedge clk);
    if (r) begin
      q.delete();
      drops = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc && s) begin
        if (classify(d, er, b, ne)) q.push_back(ne);
        else if (drops < 65535) drops++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic dr);
    bit acc;
    tick('0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, dr, 1'b0, acc);
  endtask

  // drm: 0 = desc_ready low, 1 = high, 2 = random per cycle
  task automatic send_tlp(input logic [255:0] hdr, input int nb, input bit trunc,
                          input logic er, input logic [7:0] b, input int drm);
    for (int i = 0; i < nb; i++) begin
      logic [255:0] d;
      logic         s, e, dr;
      bit           acc;
      int           tries;
      d = (i == 0) ? hdr : {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
      s = (i == 0);
      e = (i == nb - 1) && !trunc;
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 64) begin
        dr = (drm == 2) ? ($urandom_range(0, 3) != 0) : (drm == 1);
        tick(d, s, e, 1'b1, er, b, dr, 1'b0, acc);
        tries++;
      end
      chk("send_accept", acc, 1);
    end
  endtask

  function automatic logic [255:0] mrd(input logic [7:0] tag, input logic [31:0] addr);
    return mk(2'b00, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h0100, tag, 4'hF, addr, 32'h0, 32'h0);
  endfunction

  initial begin
    bit acc;
    rst = 1'b1; rx_st_data = '0; rx_st_sop = 0; rx_st_eop = 0; rx_st_valid = 0;
    rx_st_err = 0; rx_st_bar = '0; desc_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_ready", rx_st_ready, 1);
    chk("rst_valid", desc_valid, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_addr", desc_addr, 0);
    chk("rst_tag", desc_tag, 0);

    // single MRd, one-cycle latency
    send_tlp(mk(2'b00, 5'd0, 10'd1, 1'b0, 3'd0, 2'd0, 16'h0100, 8'h05, 4'hF,
                32'h0000_1004, 32'h0, 32'h0), 1, 0, 1'b0, 8'h01, 0);
    chk("mrd_valid", desc_valid, 1);
    chk("mrd_is_wr", desc_is_wr, 0);
    chk("mrd_addr", desc_addr, 62'h401);
    chk("mrd_tag", desc_tag, 8'h05);
    chk("mrd_ur", desc_ur, 0);
    idle(1'b1); idle(1'b1);

    // 3DW and 4DW writes in order
    send_tlp(mk(2'b10, 5'd0, 10'd1, 1'b0, 3'd1, 2'd1, 16'h0200, 8'h10, 4'h3,
                32'h0000_0008, 32'hAAAA_5555, 32'hDEAD_BEEF), 1, 0, 1'b0, 8'h01, 0);
    send_tlp(mk(2'b11, 5'd0, 10'd1, 1'b0, 3'd2, 2'd2, 16'h0300, 8'h11, 4'hC,
                32'h0000_0001, 32'h0000_0100, 32'h1234_5678), 1, 0, 1'b0, 8'h01, 0);
    chk("wr1_wdata", desc_wdata, 32'hDEAD_BEEF);
    idle(1'b1);
    chk("wr2_wdata", desc_wdata, 32'h1234_5678);
    idle(1'b1); idle(1'b1);

    // UR and drop sequence
    send_tlp(mk(2'b00, 5'd0, 10'd2, 1'b0, 3'd0, 2'd0, 16'h0400, 8'h20, 4'hF,
                32'h100, 32'h0, 32'h0), 1, 0, 1'b0, 8'h01, 0);
    send_tlp(mk(2'b00, 5'b00100, 10'd1, 1'b0, 3'd0, 2'd0, 16'h0401, 8'h21, 4'hF,
                32'h0, 32'h0, 32'h0), 1, 0, 1'b0, 8'h00, 0);
    send_tlp(mk(2'b10, 5'd0, 10'd4, 1'b0, 3'd0, 2'd0, 16'h0402, 8'h22, 4'hF,
                32'h200, 32'h0, 32'h0), 2, 0, 1'b0, 8'h01, 0);
    send_tlp(mk(2'b01, 5'b10000, 10'd0, 1'b0, 3'd0, 2'd0, 16'h0403, 8'h23, 4'h0,
                32'h0, 32'h0, 32'h0), 1, 0, 1'b0, 8'h00, 0);
    chk("seq_drop_cnt", drop_cnt, 16'd2);
    chk("seq_ur1", desc_ur, 1);
    idle(1'b1);
    chk("seq_ur2", desc_ur, 1);
    idle(1'b1); idle(1'b1);

    // backpressure with FIFO_DEPTH+1 reads
    for (int i = 0; i < DEPTH; i++) send_tlp(mrd(8'(8'h30 + i), 32'h40 + i * 4), 1, 0, 1'b0, 8'h01, 0);
    chk("full_ready", rx_st_ready, 0);
    tick(mrd(8'h34, 32'h50), 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, acc);
    chk("pop_ready", rx_st_ready, 1);
    send_tlp(mrd(8'h34, 32'h50), 1, 0, 1'b0, 8'h01, 0);
    repeat (6) idle(1'b1);

    // reset in the middle of a TLP with descriptors queued
    send_tlp(mrd(8'h40, 32'h60), 1, 0, 1'b0, 8'h01, 0);
    send_tlp(mrd(8'h41, 32'h64), 1, 0, 1'b0, 8'h01, 0);
    tick(mrd(8'h42, 32'h68), 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, acc);
    tick({8{32'hCAFE_F00D}}, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, acc);
    chk("mid_rst_valid", desc_valid, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_ready", rx_st_ready, 1);
    chk("mid_rst_tag", desc_tag, 0);
    tick({8{32'h1111_2222}}, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    send_tlp(mrd(8'h43, 32'h70), 1, 0, 1'b0, 8'h01, 0);
    chk("post_rst_valid", desc_valid, 1);
    chk("post_rst_tag", desc_tag, 8'h43);
    idle(1'b1); idle(1'b1);

    // random traffic
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  fmt;
      logic [4:0]  typ;
      logic [9:0]  len;
      int          kind;
      kind = $urandom_range(0, 6);
      len  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 4)) : 10'd1;
      case (kind)
        0: begin fmt = 2'b00; typ = 5'd0; end
        1: begin fmt = 2'b01; typ = 5'd0; end
        2: begin fmt = 2'b10; typ = 5'd0; end
        3: begin fmt = 2'b11; typ = 5'd0; end
        4: begin
          fmt = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
          case ($urandom_range(0, 3))
            0: typ = 5'b00010;
            1: typ = 5'b00100;
            2: typ = 5'b00101;
            default: begin typ = 5'b00001; fmt = 2'b00; end
          endcase
        end
        5: begin fmt = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01; typ = 5'(5'b10000 | $urandom_range(0, 7)); end
        default: begin fmt = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00; typ = 5'b01010; end
      endcase
      send_tlp(mk(fmt, typ, len, $urandom_range(0, 5) == 0, 3'($urandom), 2'($urandom),
                  16'($urandom), 8'($urandom), 4'($urandom), $urandom, $urandom, $urandom),
               $urandom_range(1, 3), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
               8'h01 << $urandom_range(0, 2), 2);
      if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
    end
    repeat (DEPTH + 2) idle(1'b1);
    chk("final_empty", desc_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
